wb_slave_mem: RTL

//  Wishbone classic-cycle slave: word-addressed SRAM responding to the CPU's wbi/wbd master ports.
//  One instance per port in cpu_tb_top (instruction, data); also usable as on-chip RAM.

---
 rtl/wb_slave_mem.sv | 118 +++++++++++
 1 files changed

// File: rtl/wb_slave_mem.sv
// Wishbone classic-cycle SRAM slave with programmable wait states,
// byte-lane writes and error termination on bad addresses.
module wb_slave_mem #(
  parameter int          MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wb_cyc_i,
  input  logic        wb_stb_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        wb_err_o
);

  localparam int AW = $clog2(MEM_WORDS);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        we_q;
  logic [31:0] adr_q;
  logic [3:0]  sel_q;
  logic [31:0] dat_q;

  logic [31:0] mem [MEM_WORDS];

  logic [31:0]   cur_adr;
  logic          cur_we;
  logic [29:0]   off_w;
  logic          bad;
  logic [AW-1:0] idx;
  logic          req;
  logic          resp_go;

  // Decode the live bus in IDLE (zero-wait path), the latched copy after.
  always_comb begin
    cur_adr = (state == IDLE) ? wb_adr_i : adr_q;
    cur_we  = (state == IDLE) ? wb_we_i : we_q;
    off_w   = 30'((cur_adr - BASE_ADDR) >> 2);
    bad     = (cur_adr[1:0] != 2'b00) ||
              ({2'b00, off_w} >= 32'(MEM_WORDS));
    idx     = off_w[AW-1:0];
    req     = wb_cyc_i && wb_stb_i;
    resp_go = (state == IDLE && req && WAIT_STATES == 0) ||
              (state == WAIT && wb_cyc_i && cnt == 4'd0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      we_q     <= 1'b0;
      adr_q    <= '0;
      sel_q    <= '0;
      dat_q    <= '0;
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      wb_dat_o <= '0;
      unique case (state)
        IDLE: begin
          if (req) begin
            we_q  <= wb_we_i;
            adr_q <= wb_adr_i;
            sel_q <= wb_sel_i;
            dat_q <= wb_dat_i;
            if (WAIT_STATES > 0) begin
              state <= WAIT;
              cnt   <= 4'(WAIT_STATES - 1);
            end else begin
              state <= RESP;
            end
          end
        end
        WAIT: begin
          if (!wb_cyc_i) begin
            state <= IDLE;
          end else if (cnt == 4'd0) begin
            state <= RESP;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP: state <= IDLE;
        default: state <= IDLE;
      endcase
      if (resp_go) begin
        wb_ack_o <= !bad;
        wb_err_o <= bad;
        wb_dat_o <= (!bad && !cur_we) ? mem[idx] : '0;
      end
    end
  end

  // Writes commit at the end of the ack cycle; err never writes.
  always_ff @(posedge clk) begin
    if (!rst && wb_ack_o && we_q) begin
      for (int b = 0; b < 4; b++) begin
        if (sel_q[b]) mem[idx][8*b +: 8] <= dat_q[8*b +: 8];
      end
    end
  end

endmodule
